// File: rtl/spi_mem_loader_if.sv
// Byte-access request/acknowledge port between the SPI loader and the PSRAM mux.
interface spi_mem_loader_if #(
    parameter int ADDR_W = 23
);
    logic [ADDR_W-2:0] mem_a;
    logic [15:0]       mem_do;
    logic [15:0]       mem_di;
    logic [1:0]        mem_be;
    logic              mem_we;
    logic              mem_req;
    logic              mem_ack;

    modport master (
        output mem_a, mem_do, mem_be, mem_we, mem_req,
        input  mem_di, mem_ack
    );

    modport slave (
        input  mem_a, mem_do, mem_be, mem_we, mem_req,
        output mem_di, mem_ack
    );
endinterface

// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave turning MCU frames (cmd, 3 addr bytes, data) into byte PSRAM requests; SCK edge acts 3 CLK later.
// Backpressure: one holding byte for writes, one prefetch byte for reads; a byte with nowhere to go sets sticky OVR.
module spi_mem_loader #(
    parameter int ADDR_W = 23
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_spi_ss,
    input  logic             i_spi_sck,
    input  logic             i_spi_mosi,
    output logic             o_spi_miso,
    output logic             o_busy,
    output logic             o_ovr,
    spi_mem_loader_if.master mem
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_SKIP  = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic [2:0]        r_ss_s;
    logic [2:0]        r_sck_s;
    logic [1:0]        r_mosi_s;
    logic [2:0]        r_state;
    logic [2:0]        r_bit_cnt;
    logic [1:0]        r_addr_cnt;
    logic [6:0]        r_shift;
    logic [6:0]        r_tx;
    logic [7:0]        r_hold;
    logic [7:0]        r_pf;
    logic              r_hold_vld;
    logic              r_pf_vld;
    logic              r_pf_need;
    logic              r_wr_mode;
    logic              r_miso;
    logic              r_ovr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-2:0] r_mem_a;
    logic [15:0]       r_mem_do;
    logic [1:0]        r_mem_be;
    logic              r_mem_we;
    logic              r_mem_req;

    logic       w_ss_high;
    logic       w_ss_fall;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_byte_done;
    logic       w_rd_ack;
    logic [7:0] w_byte;
    logic [7:0] w_rd_byte;
    logic [7:0] w_tx_next;

    assign w_ss_high   = r_ss_s[1];
    assign w_ss_fall   = r_ss_s[2] & ~r_ss_s[1];
    assign w_sck_rise  = ~r_sck_s[2] & r_sck_s[1];
    assign w_sck_fall  = r_sck_s[2] & ~r_sck_s[1];
    assign w_byte      = {r_shift, r_mosi_s[1]};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
    assign w_rd_ack    = r_mem_req && mem.mem_ack && !r_mem_we;
    // Byte lane follows the enable of the request being acknowledged, not the live address.
    assign w_rd_byte   = r_mem_be[0] ? mem.mem_di[7:0] : mem.mem_di[15:8];
    assign w_tx_next   = r_pf_vld ? r_pf : 8'hFF;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ss_s     <= 3'b111;
            r_sck_s    <= 3'b000;
            r_mosi_s   <= 2'b00;
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_addr_cnt <= 2'd0;
            r_shift    <= 7'd0;
            r_tx       <= 7'd0;
            r_hold     <= 8'd0;
            r_pf       <= 8'd0;
            r_hold_vld <= 1'b0;
            r_pf_vld   <= 1'b0;
            r_pf_need  <= 1'b0;
            r_wr_mode  <= 1'b0;
            r_miso     <= 1'b0;
            r_ovr      <= 1'b0;
            r_addr     <= '0;
            r_mem_a    <= '0;
            r_mem_do   <= 16'd0;
            r_mem_be   <= 2'b00;
            r_mem_we   <= 1'b0;
            r_mem_req  <= 1'b0;
        end else begin
            r_ss_s   <= {r_ss_s[1:0], i_spi_ss};
            r_sck_s  <= {r_sck_s[1:0], i_spi_sck};
            r_mosi_s <= {r_mosi_s[0], i_spi_mosi};

            // Memory port: a pending write byte takes priority over a read prefetch.
            if (r_mem_req) begin
                if (mem.mem_ack) begin
                    r_mem_req <= 1'b0;
                end
            end else if (r_hold_vld) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b1;
                r_mem_a    <= r_addr[ADDR_W-1:1];
                r_mem_do   <= {r_hold, r_hold};
                r_mem_be   <= r_addr[0] ? 2'b01 : 2'b10;
                r_addr     <= r_addr + ADDR_ONE;
                r_hold_vld <= 1'b0;
            end else if (r_pf_need) begin
                r_mem_req <= 1'b1;
                r_mem_we  <= 1'b0;
                r_mem_a   <= r_addr[ADDR_W-1:1];
                r_mem_be  <= r_addr[0] ? 2'b01 : 2'b10;
                r_pf_need <= 1'b0;
            end

            if (w_rd_ack && r_state == S_RDATA) begin
                r_pf     <= w_rd_byte;
                r_pf_vld <= 1'b1;
                r_addr   <= r_addr + ADDR_ONE;
            end

            if (w_ss_high) begin
                r_state   <= S_IDLE;
                r_pf_need <= 1'b0;
                r_pf_vld  <= 1'b0;
                r_miso    <= 1'b0;
            end else if (w_ss_fall) begin
                r_state    <= S_CMD;
                r_bit_cnt  <= 3'd0;
                r_addr_cnt <= 2'd0;
                r_ovr      <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (w_sck_rise) begin
                    r_shift   <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end

                if (w_byte_done) begin
                    case (r_state)
                        S_CMD: begin
                            if (w_byte == 8'hA5) begin
                                r_state   <= S_ADDR;
                                r_wr_mode <= 1'b1;
                            end else if (w_byte == 8'h5A) begin
                                r_state   <= S_ADDR;
                                r_wr_mode <= 1'b0;
                            end else begin
                                r_state <= S_SKIP;
                            end
                        end
                        S_ADDR: begin
                            r_addr     <= {r_addr[ADDR_W-9:0], w_byte};
                            r_addr_cnt <= r_addr_cnt + 2'd1;
                            if (r_addr_cnt == 2'd2) begin
                                r_state <= r_wr_mode ? S_WDATA : S_RDATA;
                                if (!r_wr_mode) begin
                                    r_pf_need <= 1'b1;
                                    r_pf_vld  <= 1'b0;
                                end
                            end
                        end
                        S_WDATA: begin
                            if (r_hold_vld && r_mem_req) begin
                                r_ovr <= 1'b1;
                            end else begin
                                r_hold     <= w_byte;
                                r_hold_vld <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end

                // A late prefetch is not re-requested: the one in flight serves the next byte.
                if (w_sck_fall) begin
                    if (r_state == S_RDATA) begin
                        if (r_bit_cnt == 3'd0) begin
                            r_tx   <= w_tx_next[6:0];
                            r_miso <= w_tx_next[7];
                            if (r_pf_vld) begin
                                r_pf_vld  <= 1'b0;
                                r_pf_need <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                        end else begin
                            r_tx   <= {r_tx[5:0], 1'b0};
                            r_miso <= r_tx[6];
                        end
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_spi_miso  = r_miso;
    assign o_ovr       = r_ovr;
    assign o_busy      = (r_state != S_IDLE) | r_mem_req | r_hold_vld;
    assign mem.mem_a   = r_mem_a;
    assign mem.mem_do  = r_mem_do;
    assign mem.mem_be  = r_mem_be;
    assign mem.mem_we  = r_mem_we;
    assign mem.mem_req = r_mem_req;
endmodule
